dram_dbg_arbiter: RTL and testbench
===================================

Name: dram_dbg_arbiter

Overview:
- Shares the data RAM (1R1W, synchronous read) between the CPU load/store pipeline and the debug monitor.
- Accepts debug read/write requests over a level req / pulse ack handshake.
- Drives the memory-access stage's debug override controls (d_read_sel, d_ram_wen, addresses, write data).
- Issues a debug access in a cycle free of CPU conflict; if no free cycle comes within WAIT_MAX cycles, it requests a pipeline stall and issues under the stall.

Parameters:
- WAIT_MAX, 4: conflict cycles tolerated in ARB before a stall is requested; legal range 1..7.
- CNT_W, 3: width of the wait counter; must satisfy 2**CNT_W > WAIT_MAX.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- dbg_req  input  1  debug request, level; held until dbg_ack is seen
- dbg_we  input  1  1 = write, 0 = read; stable while dbg_req is high
- dbg_adr  input  12  word address [13:2]
- dbg_wdata  input  32  write data
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  32  read data; valid while dbg_ack = 1, held afterwards
- cpu_ld_ex  input  1  CPU load in EX this cycle (read port busy)
- cpu_st_ma  input  1  CPU store in MA this cycle (write port busy)
- stall_dly  input  1  pipeline stall delayed by one cycle (load result already rolled)
- stall_req  output  1  stall request to the pipeline stall controller
- d_read_sel  output  1  read-port debug override
- d_ram_radr  output  12  debug read address
- d_ram_wen  output  1  write-port debug override, full word
- d_ram_wadr  output  12  debug write address
- d_ram_wdata  output  32  debug write data
- d_ram_rdata  input  32  RAM read data, one cycle after the address

Behaviour:
- Reset values:
  - State = IDLE.
  - dbg_ack, stall_req, d_read_sel, d_ram_wen = 0.
  - dbg_rdata, the address register and the wdata register = 0.
  - wait_cnt = 0.
- States: IDLE, ARB, STALLW, RD_ISSUE, RD_CAP, WR_ISSUE, ACK.
- IDLE:
  - If dbg_req = 1, latch dbg_we, dbg_adr and dbg_wdata into registers, clear wait_cnt, and go to ARB.
- ARB:
  - If dbg_req = 0 (abort), go to IDLE with no RAM access.
  - Free condition: ~cpu_ld_ex for a read, ~cpu_st_ma for a write. If free, go to RD_ISSUE or WR_ISSUE.
  - Otherwise increment wait_cnt. If wait_cnt == WAIT_MAX-1, go to STALLW.
- STALLW:
  - stall_req = 1.
  - If dbg_req = 0, go to IDLE and drop stall_req.
  - Else, when stall_dly = 1, go to the matching ISSUE state; otherwise stay.
- RD_ISSUE:
  - d_read_sel = 1 and d_ram_radr = latched address.
  - Go to RD_CAP.
- RD_CAP:
  - Capture d_ram_rdata into dbg_rdata at the end of the cycle.
  - Go to ACK.
- WR_ISSUE:
  - d_ram_wen = 1; d_ram_wadr and d_ram_wdata = latched values.
  - Go to ACK.
- ACK:
  - dbg_ack = 1, then go to IDLE.
- d_read_sel and d_ram_wen are Moore outputs decoded from state.
- d_ram_radr, d_ram_wadr and d_ram_wdata always drive the latched registers.
- stall_req:
  - Registered; set on the transition into STALLW.
  - Held through ISSUE, RD_CAP and ACK; cleared on the transition out of ACK or on abort.
  - Because the debug read port override is only used with stall_dly = 1 on the stalled path, the pipeline's rolled load data is never corrupted.
- Latency, free path: request seen in IDLE at cycle 0; dbg_ack at cycle 4 for a read, cycle 3 for a write.
- Once an ISSUE state is entered, the access completes even if dbg_req drops.
- Requester rules:
  - dbg_req must be low in the cycle after dbg_ack.
  - A request re-raised in that cycle is not required to be seen.
- Only one outstanding request is allowed; there is no queueing.
- Reset mid-operation: asynchronously returns to IDLE; all outputs go to their reset values, including an active stall_req and an in-flight write enable.
- At most one of d_read_sel and d_ram_wen is high in any cycle.

Test Plan:
- Read, no conflict: RAM[0x010] = 0xDEADBEEF, dbg_req/read/adr = 0x010, cpu_ld_ex = 0.
  - d_read_sel high at cycle 2 only; dbg_ack at cycle 4 with dbg_rdata = 0xDEADBEEF; stall_req stays 0.
- Write, no conflict: adr 0x020, wdata 0x12345678.
  - d_ram_wen high at cycle 2 with wadr 0x020; dbg_ack at cycle 3.
  - A following read returns 0x12345678.
- Write under a store burst, WAIT_MAX = 4: cpu_st_ma held high.
  - stall_req rises after 4 ARB cycles; no d_ram_wen until stall_dly = 1.
  - Then a single write pulse, ack, and stall_req low in the cycle after ack.
- Transient conflict: cpu_ld_ex high for 2 cycles of a read.
  - Read issues on the first free cycle; stall_req never asserts.
- Abort: dbg_req dropped during STALLW.
  - Returns to IDLE next cycle; stall_req low; no RAM access; no dbg_ack.
- Reset mid-write: rst pulsed during WR_ISSUE.
  - d_ram_wen, stall_req and dbg_ack are 0 immediately (asynchronously); state IDLE after release.

Source files
------------

// File: rtl/dram_dbg_arbiter.sv
// rtl/dram_dbg_arbiter.sv - debug monitor access arbiter for the shared 1R1W data RAM
module dram_dbg_arbiter #(
  parameter int WAIT_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [11:0] dbg_adr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  input  logic        cpu_ld_ex,
  input  logic        cpu_st_ma,
  input  logic        stall_dly,
  output logic        stall_req,
  output logic        d_read_sel,
  output logic [11:0] d_ram_radr,
  output logic        d_ram_wen,
  output logic [11:0] d_ram_wadr,
  output logic [31:0] d_ram_wdata,
  input  logic [31:0] d_ram_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    STALLW   = 3'd2,
    RD_ISSUE = 3'd3,
    RD_CAP   = 3'd4,
    WR_ISSUE = 3'd5,
    ACK      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state;
  logic             we_q;
  logic [11:0]      adr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             port_free;

  // The port we need is free when the CPU is not using it this cycle
  assign port_free = we_q ? ~cpu_st_ma : ~cpu_ld_ex;

  // Overrides are pure state decodes, so reset clears them immediately
  assign d_read_sel  = (state == RD_ISSUE);
  assign d_ram_wen   = (state == WR_ISSUE);
  assign dbg_ack     = (state == ACK);
  assign d_ram_radr  = adr_q;
  assign d_ram_wadr  = adr_q;
  assign d_ram_wdata = wdata_q;

  // Request sequencing, conflict waiting, stall handshake and read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      stall_req <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_req) begin
            we_q     <= dbg_we;
            adr_q    <= dbg_adr;
            wdata_q  <= dbg_wdata;
            wait_cnt <= '0;
            state    <= ARB;
          end
        end
        ARB: begin
          if (!dbg_req) begin
            state <= IDLE;
          end else if (port_free) begin
            state <= we_q ? WR_ISSUE : RD_ISSUE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == WAIT_LAST) begin
              state     <= STALLW;
              stall_req <= 1'b1;
            end
          end
        end
        STALLW: begin
          // Issue only once the stall has taken effect so rolled load data is safe
          if (!dbg_req) begin
            state     <= IDLE;
            stall_req <= 1'b0;
          end else if (stall_dly) begin
            state <= we_q ? WR_ISSUE : RD_ISSUE;
          end
        end
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          dbg_rdata <= d_ram_rdata;
          state     <= ACK;
        end
        WR_ISSUE: state <= ACK;
        ACK: begin
          state     <= IDLE;
          stall_req <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_dbg_arbiter.sv
// tb/tb_dram_dbg_arbiter.sv - directed self-checking bench for dram_dbg_arbiter
module tb_dram_dbg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req, dbg_we;
  logic [11:0] dbg_adr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        cpu_ld_ex, cpu_st_ma, stall_dly;
  logic        stall_req, d_read_sel, d_ram_wen;
  logic [11:0] d_ram_radr, d_ram_wadr;
  logic [31:0] d_ram_wdata, d_ram_rdata;

  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  int ld_from, ld_to, st_from, st_to, dly_from, drop_at;
  int rs_first, rs_cnt, wen_first, wen_cnt, ack_first, ack_cnt;
  int st_first, st_last, st_cnt, both_cnt;
  logic [11:0] wadr_s;
  logic [31:0] wdata_s, rdata_s;

  dram_dbg_arbiter #(.WAIT_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .cpu_ld_ex(cpu_ld_ex), .cpu_st_ma(cpu_st_ma), .stall_dly(stall_dly),
    .stall_req(stall_req), .d_read_sel(d_read_sel), .d_ram_radr(d_ram_radr),
    .d_ram_wen(d_ram_wen), .d_ram_wadr(d_ram_wadr), .d_ram_wdata(d_ram_wdata),
    .d_ram_rdata(d_ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural 1R1W synchronous-read RAM
  always @(posedge clk) begin
    if (d_ram_wen) mem[d_ram_wadr] <= d_ram_wdata;
    d_ram_rdata <= mem[d_read_sel ? d_ram_radr : 12'h000];
  end

  task automatic clear_env();
    ld_from = 999; ld_to = -1; st_from = 999; st_to = -1; dly_from = 999; drop_at = -1;
  endtask

  task automatic start_req(input logic we, input logic [11:0] adr, input logic [31:0] wd);
    dbg_we = we; dbg_adr = adr; dbg_wdata = wd; dbg_req = 1'b1;
  endtask

  // Runs n cycles (cycle 0 = request visible in IDLE) and records output activity
  task automatic run(input int n);
    rs_first = -1; rs_cnt = 0; wen_first = -1; wen_cnt = 0; ack_first = -1; ack_cnt = 0;
    st_first = -1; st_last = -1; st_cnt = 0; both_cnt = 0;
    wadr_s = '0; wdata_s = '0; rdata_s = '0;
    for (int c = 0; c < n; c++) begin
      cpu_ld_ex = (c >= ld_from && c <= ld_to);
      cpu_st_ma = (c >= st_from && c <= st_to);
      stall_dly = (c >= dly_from);
      if (d_read_sel) begin if (rs_first < 0) rs_first = c; rs_cnt++; end
      if (d_ram_wen) begin
        if (wen_first < 0) wen_first = c;
        wen_cnt++; wadr_s = d_ram_wadr; wdata_s = d_ram_wdata;
      end
      if (dbg_ack) begin if (ack_first < 0) ack_first = c; ack_cnt++; rdata_s = dbg_rdata; end
      if (stall_req) begin if (st_first < 0) st_first = c; st_last = c; st_cnt++; end
      if (d_read_sel && d_ram_wen) both_cnt++;
      if (dbg_ack || c == drop_at) dbg_req = 1'b0;
      @(posedge clk); #1;
    end
    cpu_ld_ex = 1'b0; cpu_st_ma = 1'b0; stall_dly = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", dbg_ack); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
    checks++; if (d_read_sel !== 1'b0) begin errors++; $display("FAIL reset_rsel got %b want 0", d_read_sel); end
    checks++; if (d_ram_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", d_ram_wen); end
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", dbg_rdata); end
    checks++; if (d_ram_radr !== 12'h0) begin errors++; $display("FAIL reset_adr got %h want 0", d_ram_radr); end
    checks++; if (d_ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", d_ram_wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_free();
    clear_env();
    start_req(1'b0, 12'h010, 32'h0);
    run(8);
    checks++; if (rs_first !== 2 || rs_cnt !== 1) begin errors++; $display("FAIL rd_sel first=%0d cnt=%0d want 2/1", rs_first, rs_cnt); end
    checks++; if (ack_first !== 4 || ack_cnt !== 1) begin errors++; $display("FAIL rd_ack first=%0d cnt=%0d want 4/1", ack_first, ack_cnt); end
    checks++; if (rdata_s !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rdata_s); end
    checks++; if (st_cnt !== 0) begin errors++; $display("FAIL rd_stall cnt=%0d want 0", st_cnt); end
    checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %h want deadbeef", dbg_rdata); end
  endtask

  task automatic test_write_free();
    clear_env();
    start_req(1'b1, 12'h020, 32'h12345678);
    run(6);
    checks++; if (wen_first !== 2 || wen_cnt !== 1) begin errors++; $display("FAIL wr_wen first=%0d cnt=%0d want 2/1", wen_first, wen_cnt); end
    checks++; if (wadr_s !== 12'h020 || wdata_s !== 32'h12345678) begin errors++; $display("FAIL wr_bus got %h/%h want 020/12345678", wadr_s, wdata_s); end
    checks++; if (ack_first !== 3 || ack_cnt !== 1) begin errors++; $display("FAIL wr_ack first=%0d cnt=%0d want 3/1", ack_first, ack_cnt); end
    checks++; if (rs_cnt !== 0) begin errors++; $display("FAIL wr_rsel cnt=%0d want 0", rs_cnt); end
    clear_env();
    start_req(1'b0, 12'h020, 32'h0);
    run(7);
    checks++; if (ack_first !== 4 || rdata_s !== 32'h12345678) begin errors++; $display("FAIL wr_readback ack=%0d data=%h want 4/12345678", ack_first, rdata_s); end
  endtask

  task automatic test_store_burst();
    clear_env();
    st_from = 0; st_to = 99; dly_from = 8;
    start_req(1'b1, 12'h030, 32'hA5A50F0F);
    run(14);
    checks++; if (st_first !== 5) begin errors++; $display("FAIL burst_stall_rise got %0d want 5", st_first); end
    checks++; if (wen_first !== 9 || wen_cnt !== 1) begin errors++; $display("FAIL burst_wen first=%0d cnt=%0d want 9/1", wen_first, wen_cnt); end
    checks++; if (ack_first !== 10 || ack_cnt !== 1) begin errors++; $display("FAIL burst_ack first=%0d cnt=%0d want 10/1", ack_first, ack_cnt); end
    checks++; if (st_last !== 10 || st_cnt !== 6) begin errors++; $display("FAIL burst_stall_span last=%0d cnt=%0d want 10/6", st_last, st_cnt); end
    checks++; if (mem[12'h030] !== 32'hA5A50F0F) begin errors++; $display("FAIL burst_mem got %h want a5a50f0f", mem[12'h030]); end
  endtask

  task automatic test_transient();
    clear_env();
    ld_from = 1; ld_to = 2;
    start_req(1'b0, 12'h020, 32'h0);
    run(9);
    checks++; if (rs_first !== 4 || rs_cnt !== 1) begin errors++; $display("FAIL trans_rsel first=%0d cnt=%0d want 4/1", rs_first, rs_cnt); end
    checks++; if (ack_first !== 6 || rdata_s !== 32'h12345678) begin errors++; $display("FAIL trans_ack ack=%0d data=%h want 6/12345678", ack_first, rdata_s); end
    checks++; if (st_cnt !== 0) begin errors++; $display("FAIL trans_stall cnt=%0d want 0", st_cnt); end
  endtask

  task automatic test_abort();
    clear_env();
    ld_from = 0; ld_to = 99; drop_at = 6;
    start_req(1'b0, 12'h010, 32'h0);
    run(11);
    checks++; if (st_first !== 5 || st_last !== 6) begin errors++; $display("FAIL abort_stall first=%0d last=%0d want 5/6", st_first, st_last); end
    checks++; if (rs_cnt !== 0 || wen_cnt !== 0 || ack_cnt !== 0) begin errors++; $display("FAIL abort_access rsel=%0d wen=%0d ack=%0d want 0/0/0", rs_cnt, wen_cnt, ack_cnt); end
  endtask

  task automatic test_reset_mid_write();
    mem[12'h040] = 32'h0;
    start_req(1'b1, 12'h040, 32'hCAFEF00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (d_ram_wen !== 1'b1) begin errors++; $display("FAIL rstw_wen_pre got %b want 1", d_ram_wen); end
    rst = 1'b1;
    #1;
    checks++; if (d_ram_wen !== 1'b0 || stall_req !== 1'b0 || dbg_ack !== 1'b0) begin
      errors++; $display("FAIL rstw_async wen=%b stall=%b ack=%b want 0/0/0", d_ram_wen, stall_req, dbg_ack);
    end
    dbg_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem[12'h040] !== 32'h0) begin errors++; $display("FAIL rstw_mem got %h want 0", mem[12'h040]); end
    clear_env();
    start_req(1'b0, 12'h010, 32'h0);
    run(7);
    checks++; if (rs_first !== 2 || ack_first !== 4 || rdata_s !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rstw_after rsel=%0d ack=%0d data=%h want 2/4/deadbeef", rs_first, ack_first, rdata_s);
    end
  endtask

  task automatic test_reset_stall();
    clear_env();
    st_from = 0; st_to = 99;
    start_req(1'b1, 12'h050, 32'h11112222);
    run(7);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rsts_pre got %b want 1", stall_req); end
    rst = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rsts_async got %b want 0", stall_req); end
    dbg_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (both_cnt !== 0 && mem[12'h050] !== 32'h0) begin errors++; $display("FAIL rsts_mem got %h want 0", mem[12'h050]); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hDEADBEEF;
    rst = 1'b1; dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_wdata = '0;
    cpu_ld_ex = 1'b0; cpu_st_ma = 1'b0; stall_dly = 1'b0;
    clear_env();
    #2;
    test_reset();
    test_read_free();
    test_write_free();
    test_store_burst();
    test_transient();
    test_abort();
    test_reset_mid_write();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
